fsm_core: RTL and testbench
===========================

Name: fsm_core

Overview:
- Multi-cycle RV32I subset processor core built around a 5-state control FSM.
- Per instruction: fetch from external instruction ROM (`instr`), decode, execute, optional single data-RAM access, writeback.
- Owns the 32x32 register file and the PC.
- Sits between the instruction ROM and data RAM in the CPU top level.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 16, width of the data-memory address output.

Ports:
- clk  in  1  system clock, rising-edge active
- rst  in  1  asynchronous active-low reset
- instr  in  32  instruction word from ROM; valid during FETCH
- mem_rdata  in  32  data-RAM read data; valid during MEMORY
- rom_ce  out  1  ROM chip enable; high only in FETCH
- ram_ce  out  1  RAM chip enable; high only in MEMORY for LW/SW
- pc  out  32  current instruction address
- mem_read  out  1  high in MEMORY for LW
- mem_write  out  1  high in MEMORY for SW
- mem_addr  out  ADDR_W  low ADDR_W bits of rs1+imm
- mem_wdata  out  32  rs2 value for SW

Behaviour:
- Reset (rst=0, async):
  - state=FETCH, pc=RESET_PC.
  - IR, regfile[0..31] and all internal registers cleared.
  - All outputs 0, except pc.
- FSM: FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK -> FETCH. Every instruction takes exactly 5 cycles, with no stalls.
- FETCH: rom_ce=1; IR<=instr at the clock edge.
- DECODE: read rs1/rs2 from regfile; generate immediate in I/S/B/U/J format, sign-extended.
- EXECUTE: ALU result registered; branch condition evaluated; memory address registered.
- MEMORY:
  - LW: ram_ce=1, mem_read=1; mem_rdata captured at the end of the cycle.
  - SW: ram_ce=1, mem_write=1, mem_wdata=rs2.
  - Other instructions: no strobes asserted.
- WRITEBACK:
  - Write rd when rd!=0; x0 always reads 0, and writes to it are discarded.
  - Update pc: pc+4 by default; pc+imm for a taken branch or JAL; (rs1+imm)&~1 for JALR.
- Supported instructions:
  - LUI (rd=imm<<12).
  - AUIPC.
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - OP: ADD, SUB (funct7[5]=1), SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - LW, SW.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - JAL, JALR; both write pc+4 to rd.
- Arithmetic: all ALU operations are 32-bit modulo 2^32. Shift amount = low 5 bits of the operand. SLT is signed; SLTU is unsigned.
- mem_addr truncation: bits above ADDR_W are dropped. Alignment is not checked; LW/SW are always word-wide.
- Unknown opcodes execute as NOP: no register or memory effect, pc+=4.
- pc wraps modulo 2^32.
- instr and mem_rdata are ignored outside FETCH and MEMORY respectively.
- Reset mid-instruction aborts it; any writeback not yet performed is lost.
- Register file is an internal array named regfile, so benches can inspect it hierarchically.

Optional Feature:
- Macro FSM_BRANCH_EN.
- Defined: BRANCH, JAL and JALR are implemented as above.
- Undefined: those opcodes execute as NOP (pc+=4, no rd write), and the branch/jump datapath is omitted.

Test Plan:
- Reset low for 5 cycles, then release -> pc=0, rom_ce=1 on the first cycle; mem_read/mem_write/ram_ce=0.
- ADDI x1,x0,5 (00500093), then ADDI x2,x0,10 (00A00113), then ADD x3,x1,x2 (002081B3) -> x1=5, x2=10, x3=15; pc advances by 4 every 5 cycles.
- SUB x4,x2,x1 (40110233); AND (0020F2B3); OR (0020E333); XOR (0020C3B3); SLL x9,x1,x1 (001094B3) -> x4=5, x5=0, x6=15, x7=15, x9=160.
- LUI x8,0x12345 (12345437) -> x8=0x12345000. ADDI x0,x0,7 -> x0 stays 0.
- SW x2,8(x0), then LW x10,8(x0) with mem_rdata=0xDEADBEEF:
  - SW -> in MEMORY, mem_write=1, ram_ce=1, mem_addr=8, mem_wdata=10.
  - LW -> mem_read=1, then x10=0xDEADBEEF.
- With FSM_BRANCH_EN: BEQ x0,x0,+16 at pc=P -> pc=P+16. JAL x1,+8 -> x1=P+4, pc=P+8. Without FSM_BRANCH_EN -> pc=P+4, x1 unchanged.

Source files
------------

// File: rtl/fsm_core.sv
// Multi-cycle RV32I-subset core: 5-state control FSM, register file and PC.
// Optional macro FSM_BRANCH_EN enables BRANCH/JAL/JALR; otherwise they run as NOPs.
module fsm_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic [31:0]       mem_rdata,
    output logic              rom_ce,
    output logic              ram_ce,
    output logic [31:0]       pc,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_N = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
`ifdef FSM_BRANCH_EN
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
`endif

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK
    } state_t;

    state_t state, state_next;

    logic [XLEN-1:0] regfile [REG_N];
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] rs1_q, rs2_q, imm_q;
    logic [XLEN-1:0] alu_q, load_q, npc_q;
    logic            fetch_q;
    logic            fetch_d, ram_ce_d, mem_read_d, mem_write_d;

    // Instruction field decode; IR is stable from DECODE through WRITEBACK
    logic [6:0] opcode;
    logic [4:0] rd_a, rs1_a, rs2_a;
    logic [2:0] funct3;
    logic       f7b5;
    logic       is_lui, is_auipc, is_opimm, is_op, is_lw, is_sw, wb_en;

    assign opcode   = ir[6:0];
    assign rd_a     = ir[11:7];
    assign funct3   = ir[14:12];
    assign rs1_a    = ir[19:15];
    assign rs2_a    = ir[24:20];
    assign f7b5     = ir[30];
    assign is_lui   = (opcode == OPC_LUI);
    assign is_auipc = (opcode == OPC_AUIPC);
    assign is_opimm = (opcode == OPC_OPIMM);
    assign is_op    = (opcode == OPC_OP);
    assign is_lw    = (opcode == OPC_LOAD)  && (funct3 == 3'b010);
    assign is_sw    = (opcode == OPC_STORE) && (funct3 == 3'b010);

`ifdef FSM_BRANCH_EN
    logic is_br, is_jal, is_jalr, br_taken;
    assign is_br   = (opcode == OPC_BRANCH);
    assign is_jal  = (opcode == OPC_JAL);
    assign is_jalr = (opcode == OPC_JALR);
    assign wb_en   = is_lui | is_auipc | is_opimm | is_op | is_lw | is_jal | is_jalr;
`else
    assign wb_en   = is_lui | is_auipc | is_opimm | is_op | is_lw;
`endif

    // Sign-extended immediate by instruction format
    logic [XLEN-1:0] imm_c;
    always_comb begin
        imm_c = '0;
        case (opcode)
            OPC_OPIMM, OPC_LOAD: imm_c = {{20{ir[31]}}, ir[31:20]};
            OPC_STORE:           imm_c = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OPC_LUI, OPC_AUIPC:  imm_c = {ir[31:12], 12'b0};
`ifdef FSM_BRANCH_EN
            OPC_JALR:            imm_c = {{20{ir[31]}}, ir[31:20]};
            OPC_BRANCH:          imm_c = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            OPC_JAL:             imm_c = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
`endif
            default:             imm_c = '0;
        endcase
    end

    logic [XLEN-1:0] rf_rs1, rf_rs2;
    assign rf_rs1 = (rs1_a == 5'd0) ? '0 : regfile[rs1_a];
    assign rf_rs2 = (rs2_a == 5'd0) ? '0 : regfile[rs2_a];

    // ALU: OP uses rs2, OP-IMM uses the immediate; shifts use the low 5 bits
    logic [XLEN-1:0] alu_b, alu_out, wb_val;
    logic [4:0]      shamt;
    assign alu_b = is_op ? rs2_q : imm_q;
    assign shamt = alu_b[4:0];

    always_comb begin
        alu_out = '0;
        case (funct3)
            3'b000:  alu_out = (is_op && f7b5) ? (rs1_q - alu_b) : (rs1_q + alu_b);
            3'b001:  alu_out = rs1_q << shamt;
            3'b010:  alu_out = {31'b0, ($signed(rs1_q) < $signed(alu_b))};
            3'b011:  alu_out = {31'b0, (rs1_q < alu_b)};
            3'b100:  alu_out = rs1_q ^ alu_b;
            3'b101:  alu_out = f7b5 ? XLEN'($signed(rs1_q) >>> shamt) : (rs1_q >> shamt);
            3'b110:  alu_out = rs1_q | alu_b;
            default: alu_out = rs1_q & alu_b;
        endcase
    end

    logic [XLEN-1:0] npc_c;
`ifdef FSM_BRANCH_EN
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (rs1_q == rs2_q);
            3'b001:  br_taken = (rs1_q != rs2_q);
            3'b100:  br_taken = ($signed(rs1_q) <  $signed(rs2_q));
            3'b101:  br_taken = ($signed(rs1_q) >= $signed(rs2_q));
            3'b110:  br_taken = (rs1_q <  rs2_q);
            3'b111:  br_taken = (rs1_q >= rs2_q);
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        npc_c  = pc + 32'd4;
        wb_val = alu_out;
        if (is_jal || (is_br && br_taken)) begin
            npc_c = pc + imm_q;
        end else if (is_jalr) begin
            npc_c = (rs1_q + imm_q) & ~32'd1;
        end
        if (is_lui) begin
            wb_val = imm_q;
        end else if (is_auipc) begin
            wb_val = pc + imm_q;
        end else if (is_jal || is_jalr) begin
            wb_val = pc + 32'd4;
        end
    end
`else
    always_comb begin
        npc_c  = pc + 32'd4;
        wb_val = alu_out;
        if (is_lui) begin
            wb_val = imm_q;
        end else if (is_auipc) begin
            wb_val = pc + imm_q;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus next values of the registered strobes
    always_comb begin
        state_next  = state;
        fetch_d     = 1'b0;
        ram_ce_d    = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        case (state)
            S_FETCH:     state_next = S_DECODE;
            S_DECODE:    state_next = S_EXECUTE;
            S_EXECUTE:   state_next = S_MEMORY;
            S_MEMORY:    state_next = S_WRITEBACK;
            S_WRITEBACK: state_next = S_FETCH;
            default:     state_next = S_FETCH;
        endcase
        fetch_d = (state_next == S_FETCH);
        if (state_next == S_MEMORY) begin
            ram_ce_d    = is_lw | is_sw;
            mem_read_d  = is_lw;
            mem_write_d = is_sw;
        end
    end

    // Reset parks the FSM in FETCH, so the ROM enable is live as soon as reset lifts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_q   <= 1'b1;
            ram_ce    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            fetch_q   <= fetch_d;
            ram_ce    <= ram_ce_d;
            mem_read  <= mem_read_d;
            mem_write <= mem_write_d;
        end
    end

    assign rom_ce = fetch_q & rst;

    // Datapath registers, register file and PC
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc        <= RESET_PC;
            ir        <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            alu_q     <= '0;
            load_q    <= '0;
            npc_q     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            for (int unsigned i = 0; i < REG_N; i++) begin
                regfile[i] <= '0;
            end
        end else begin
            case (state)
                S_FETCH: begin
                    ir <= instr;
                end
                S_DECODE: begin
                    rs1_q <= rf_rs1;
                    rs2_q <= rf_rs2;
                    imm_q <= imm_c;
                end
                S_EXECUTE: begin
                    alu_q     <= wb_val;
                    npc_q     <= npc_c;
                    mem_addr  <= ADDR_W'(rs1_q + imm_q);
                    mem_wdata <= is_sw ? rs2_q : '0;
                end
                S_MEMORY: begin
                    if (is_lw) begin
                        load_q <= mem_rdata;
                    end
                end
                S_WRITEBACK: begin
                    if (wb_en && (rd_a != 5'd0)) begin
                        regfile[rd_a] <= is_lw ? load_q : alu_q;
                    end
                    pc <= npc_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_core.sv
// Scoreboard bench for fsm_core: driver pushes expected fetch/memory events,
// a negedge monitor pops and compares them as the core presents rom_ce / ram_ce.
module tb_fsm_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] mem_rdata;
    logic        rom_ce, ram_ce, mem_read, mem_write;
    logic [31:0] pc;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;

    always #5 clk = ~clk;

    fsm_core #(.RESET_PC(32'h0000_0000), .ADDR_W(16)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .mem_rdata (mem_rdata),
        .rom_ce    (rom_ce),
        .ram_ce    (ram_ce),
        .pc        (pc),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

    typedef struct {
        logic [31:0] pc;
        bit          chk;
        logic [4:0]  ridx;
        logic [31:0] rval;
    } fetch_rec_t;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] wdata;
    } mem_rec_t;

    fetch_rec_t fq[$];
    mem_rec_t   mq[$];
    fetch_rec_t mon_f;
    mem_rec_t   mon_m;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_fetch = -4;

    logic [31:0] exp_pc;
    bit          pend_chk;
    logic [4:0]  pend_idx;
    logic [31:0] pend_val;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: each rom_ce cycle closes the previous instruction and opens the next
    always @(negedge clk) begin
        if (rst) begin
            cyc++;
            if (rom_ce) begin
                check32("fetch_interval", 32'(cyc - last_fetch), 32'd5);
                last_fetch = cyc;
                if (fq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fetch_unexpected: got fetch at pc %h expected none", pc);
                end else begin
                    mon_f = fq.pop_front();
                    check32("fetch_pc", pc, mon_f.pc);
                    if (mon_f.chk) begin
                        check32($sformatf("reg_x%0d", mon_f.ridx), u_dut.regfile[mon_f.ridx], mon_f.rval);
                    end
                end
            end
            if (ram_ce || mem_read || mem_write) begin
                if (mq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_unexpected: got ce/rd/wr %b%b%b expected 000", ram_ce, mem_read, mem_write);
                end else begin
                    mon_m = mq.pop_front();
                    check32("mem_strobes", {29'b0, ram_ce, mem_read, mem_write},
                            {29'b0, 1'b1, !mon_m.wr, mon_m.wr});
                    check32("mem_addr", {16'b0, mem_addr}, {16'b0, mon_m.addr});
                    if (mon_m.wr) begin
                        check32("mem_wdata", mem_wdata, mon_m.wdata);
                    end
                end
            end
        end
    end

    task automatic wait_fetch();
        int n = 0;
        @(negedge clk);
        while (!rom_ce && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rom_ce) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: rom_ce=0 expected 1 for pc %h", exp_pc);
        end
    endtask

    // Queue the fetch (carrying the previous instruction's register check), then present the word
    task automatic issue(input logic [31:0] word, input logic [31:0] npc, input bit chk,
                         input logic [4:0] ridx, input logic [31:0] rval);
        fetch_rec_t r;
        r.pc   = exp_pc;
        r.chk  = pend_chk;
        r.ridx = pend_idx;
        r.rval = pend_val;
        fq.push_back(r);
        wait_fetch();
        instr    = word;
        pend_chk = chk;
        pend_idx = ridx;
        pend_val = rval;
        exp_pc   = npc;
    endtask

    task automatic issue_mem(input logic [31:0] word, input bit wr, input logic [15:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata, input bit chk,
                             input logic [4:0] ridx, input logic [31:0] rval);
        mem_rec_t m;
        m.wr    = wr;
        m.addr  = addr;
        m.wdata = wdata;
        mq.push_back(m);
        mem_rdata = rdata;
        issue(word, exp_pc + 32'd4, chk, ridx, rval);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        instr     = 32'h0;
        mem_rdata = 32'h0;
        exp_pc    = 32'h0;
        pend_chk  = 1'b0;
        pend_idx  = 5'd0;
        pend_val  = 32'h0;

        repeat (5) @(posedge clk);
        #1;
        check32("reset_pc", pc, 32'h0);
        check32("reset_rom_ce", {31'b0, rom_ce}, 32'd0);
        check32("reset_ram_ce", {31'b0, ram_ce}, 32'd0);
        check32("reset_mem_read", {31'b0, mem_read}, 32'd0);
        check32("reset_mem_write", {31'b0, mem_write}, 32'd0);
        check32("reset_mem_addr", {16'b0, mem_addr}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;

        issue(32'h00500093, exp_pc + 32'd4, 1'b1, 5'd1,  32'd5);
        issue(32'h00A00113, exp_pc + 32'd4, 1'b1, 5'd2,  32'd10);
        issue(32'h002081B3, exp_pc + 32'd4, 1'b1, 5'd3,  32'd15);
        issue(32'h40110233, exp_pc + 32'd4, 1'b1, 5'd4,  32'd5);
        issue(32'h0020F2B3, exp_pc + 32'd4, 1'b1, 5'd5,  32'd0);
        issue(32'h0020E333, exp_pc + 32'd4, 1'b1, 5'd6,  32'd15);
        issue(32'h0020C3B3, exp_pc + 32'd4, 1'b1, 5'd7,  32'd15);
        issue(32'h001094B3, exp_pc + 32'd4, 1'b1, 5'd9,  32'd160);
        issue(32'h12345437, exp_pc + 32'd4, 1'b1, 5'd8,  32'h1234_5000);
        issue(32'h00700013, exp_pc + 32'd4, 1'b1, 5'd0,  32'h0);
        issue_mem(32'h00202423, 1'b1, 16'd8, 32'd10, 32'h0, 1'b1, 5'd2, 32'd10);
        issue_mem(32'h00802503, 1'b0, 16'd8, 32'h0, 32'hDEAD_BEEF, 1'b1, 5'd10, 32'hDEAD_BEEF);
        issue(32'h40455593, exp_pc + 32'd4, 1'b1, 5'd11, 32'hFDEA_DBEE);
        issue(32'h00052633, exp_pc + 32'd4, 1'b1, 5'd12, 32'd1);
        issue(32'h00A036B3, exp_pc + 32'd4, 1'b1, 5'd13, 32'd1);
        issue(32'hFFFF_FFFF, exp_pc + 32'd4, 1'b1, 5'd1,  32'd5);
        issue(32'h00001717, exp_pc + 32'd4, 1'b1, 5'd14, exp_pc + 32'h1000);
`ifdef FSM_BRANCH_EN
        issue(32'h00000863, exp_pc + 32'd16, 1'b0, 5'd0, 32'h0);
        issue(32'h008000EF, exp_pc + 32'd8, 1'b1, 5'd1, exp_pc + 32'd4);
        issue(32'h101007E7, 32'h0000_0100, 1'b1, 5'd15, exp_pc + 32'd4);
`else
        issue(32'h00000863, exp_pc + 32'd4, 1'b0, 5'd0, 32'h0);
        issue(32'h008000EF, exp_pc + 32'd4, 1'b1, 5'd1, 32'd5);
        issue(32'h101007E7, exp_pc + 32'd4, 1'b1, 5'd15, 32'h0);
`endif
        issue(32'h00000013, exp_pc + 32'd4, 1'b0, 5'd0, 32'h0);
        issue(32'h00000013, exp_pc + 32'd4, 1'b0, 5'd0, 32'h0);

        repeat (3) @(negedge clk);
        check32("fetch_queue_drained", 32'(fq.size()), 32'd0);
        check32("mem_queue_drained", 32'(mq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
